// File: rtl/alu_operand_pkg.sv
// Shared encodings for the ALU operand stage: forwarding source codes
// reported on fwd_a/fwd_b and the A/B operand select constants.
package alu_operand_pkg;
   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_EXM  = 2'd1,
      FWD_MWB  = 2'd2
   } fwd_e;

   localparam logic ALUA_RS1 = 1'b0;
   localparam logic ALUA_PC  = 1'b1;
   localparam logic ALUB_RS2 = 1'b0;
   localparam logic ALUB_EXT = 1'b1;
endpackage

// File: rtl/alu_operand_stage_if.sv
// ID/EX operand bundle in, registered A/B operands out, plus the two
// writeback candidates used for forwarding. master = producer/consumer
// side, slave = the operand stage.
interface alu_operand_stage_if #(
   parameter int WIDTH   = 32,
   parameter int RADDR_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic               alua_sel;
   logic               alub_sel;
   logic [RADDR_W-1:0] rs1;
   logic [RADDR_W-1:0] rs2;
   logic [WIDTH-1:0]   rD1;
   logic [WIDTH-1:0]   rD2;
   logic [WIDTH-1:0]   pc;
   logic [WIDTH-1:0]   ext;
   logic               exm_we;
   logic [RADDR_W-1:0] exm_rd;
   logic [WIDTH-1:0]   exm_data;
   logic               mwb_we;
   logic [RADDR_W-1:0] mwb_rd;
   logic [WIDTH-1:0]   mwb_data;
   logic               flush;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   A;
   logic [WIDTH-1:0]   B;
   logic [1:0]         fwd_a;
   logic [1:0]         fwd_b;

   modport master (
      output in_valid, alua_sel, alub_sel, rs1, rs2, rD1, rD2, pc, ext,
             exm_we, exm_rd, exm_data, mwb_we, mwb_rd, mwb_data, flush, out_ready,
      input  in_ready, out_valid, A, B, fwd_a, fwd_b
   );

   modport slave (
      input  in_valid, alua_sel, alub_sel, rs1, rs2, rD1, rD2, pc, ext,
             exm_we, exm_rd, exm_data, mwb_we, mwb_rd, mwb_data, flush, out_ready,
      output in_ready, out_valid, A, B, fwd_a, fwd_b
   );
endinterface

// File: rtl/alu_operand_stage_fwd_sel.sv
// Combinational forwarding selector for one source register path.
// Forwarding is compiled in only when ALU_OPERAND_FWD_EN is defined;
// otherwise the path is the plain register-file read.
module fwd_sel
   import alu_operand_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int RADDR_W = 5
) (
   input  logic [RADDR_W-1:0] rs,
   input  logic [WIDTH-1:0]   rd_data,
   input  logic               exm_we,
   input  logic [RADDR_W-1:0] exm_rd,
   input  logic [WIDTH-1:0]   exm_data,
   input  logic               mwb_we,
   input  logic [RADDR_W-1:0] mwb_rd,
   input  logic [WIDTH-1:0]   mwb_data,
   output logic [WIDTH-1:0]   data,
   output logic [1:0]         fwd
);
`ifdef ALU_OPERAND_FWD_EN
   // Youngest writer wins; x0 is hard-wired and never forwarded.
   always_comb begin
      data = rd_data;
      fwd  = FWD_NONE;
      if (rs != '0) begin
         if (exm_we && (exm_rd == rs)) begin
            data = exm_data;
            fwd  = FWD_EXM;
         end else if (mwb_we && (mwb_rd == rs)) begin
            data = mwb_data;
            fwd  = FWD_MWB;
         end
      end
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{rs, exm_we, exm_rd, exm_data, mwb_we, mwb_rd, mwb_data};

   // Forwarding disabled: pass the register-file read straight through.
   always_comb begin
      data = rd_data;
      fwd  = FWD_NONE;
   end
`endif
endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: one-deep valid/ready register slice that resolves
// A/B from forwarded rs1/rs2 paths, pc or ext. Optional forwarding is
// enabled by the ALU_OPERAND_FWD_EN macro (see fwd_sel).
module alu_operand_stage
   import alu_operand_pkg::*;
#(
   parameter int              WIDTH    = 32,
   parameter int              RADDR_W  = 5,
   parameter longint unsigned PC_RESET = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_operand_stage_if.slave bus
);
   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(PC_RESET);
   localparam int               NPATH   = 2;

   logic [NPATH-1:0][RADDR_W-1:0] path_rs;
   logic [NPATH-1:0][WIDTH-1:0]   path_rd;
   logic [NPATH-1:0][WIDTH-1:0]   path_data;
   logic [NPATH-1:0][1:0]         path_fwd;

   assign path_rs = {bus.rs2, bus.rs1};
   assign path_rd = {bus.rD2, bus.rD1};

   // index 0 = rs1 path, index 1 = rs2 path
   for (genvar i = 0; i < NPATH; i++) begin : g_path
      fwd_sel #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) u_fwd_sel (
         .rs       (path_rs[i]),
         .rd_data  (path_rd[i]),
         .exm_we   (bus.exm_we),
         .exm_rd   (bus.exm_rd),
         .exm_data (bus.exm_data),
         .mwb_we   (bus.mwb_we),
         .mwb_rd   (bus.mwb_rd),
         .mwb_data (bus.mwb_data),
         .data     (path_data[i]),
         .fwd      (path_fwd[i])
      );
   end

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic             in_ready;
   logic             xfer;

   assign in_ready = !valid_q || bus.out_ready;
   assign xfer     = bus.in_valid && in_ready && !bus.flush;

   // Next state: flush beats everything, data only moves on a transfer.
   always_comb begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      fwd_a_d = fwd_a_q;
      fwd_b_d = fwd_b_q;
      if (bus.flush)          valid_d = 1'b0;
      else if (xfer)          valid_d = 1'b1;
      else if (bus.out_ready) valid_d = 1'b0;
      if (xfer) begin
         if (bus.alua_sel == ALUA_PC) begin
            a_d     = bus.pc;
            fwd_a_d = FWD_NONE;
         end else begin
            a_d     = path_data[0];
            fwd_a_d = path_fwd[0];
         end
         if (bus.alub_sel == ALUB_EXT) begin
            b_d     = bus.ext;
            fwd_b_d = FWD_NONE;
         end else begin
            b_d     = path_data[1];
            fwd_b_d = path_fwd[1];
         end
      end
   end

   // Output register slice; async reset drops any held bundle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         a_q     <= RST_VAL;
         b_q     <= RST_VAL;
         fwd_a_q <= FWD_NONE;
         fwd_b_q <= FWD_NONE;
      end else begin
         valid_q <= valid_d;
         a_q     <= a_d;
         b_q     <= b_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.fwd_a     = fwd_a_q;
   assign bus.fwd_b     = fwd_b_q;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed scenarios plus a
// randomized run checked against a behavioural operand-stage model.
module tb_alu_operand_stage;
   localparam int W  = 32;
   localparam int RW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_operand_stage_if #(.WIDTH(W), .RADDR_W(RW)) ifc ();

   alu_operand_stage #(.WIDTH(W), .RADDR_W(RW), .PC_RESET(0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   int checks = 0;
   int failures = 0;

   // model state
   logic         exp_valid;
   logic [W-1:0] exp_a, exp_b;
   logic [1:0]   exp_fa, exp_fb;

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      exp_valid = 0; exp_a = '0; exp_b = '0; exp_fa = 0; exp_fb = 0;
   endtask

   // source operand per the forwarding rules
   task automatic ref_src(input logic [RW-1:0] rs, input logic [W-1:0] rd,
                          output logic [W-1:0] d, output logic [1:0] f);
      d = rd; f = 0;
`ifdef ALU_OPERAND_FWD_EN
      if (rs != 0 && ifc.exm_we && ifc.exm_rd == rs) begin d = ifc.exm_data; f = 1; end
      else if (rs != 0 && ifc.mwb_we && ifc.mwb_rd == rs) begin d = ifc.mwb_data; f = 2; end
`endif
   endtask

   // advance one clock and update the model from the inputs seen at the edge
   task automatic step();
      logic [W-1:0] na, nb;
      logic [1:0]   fa, fb;
      logic         take;
      ref_src(ifc.rs1, ifc.rD1, na, fa);
      ref_src(ifc.rs2, ifc.rD2, nb, fb);
      if (ifc.alua_sel) begin na = ifc.pc;  fa = 0; end
      if (ifc.alub_sel) begin nb = ifc.ext; fb = 0; end
      take = ifc.in_valid && (!exp_valid || ifc.out_ready) && !ifc.flush;
      @(posedge clk); #1;
      if (ifc.flush)          exp_valid = 0;
      else if (take)          exp_valid = 1;
      else if (ifc.out_ready) exp_valid = 0;
      if (take) begin exp_a = na; exp_b = nb; exp_fa = fa; exp_fb = fb; end
   endtask

   task automatic idle_inputs();
      ifc.in_valid = 0; ifc.alua_sel = 0; ifc.alub_sel = 0;
      ifc.rs1 = 0; ifc.rs2 = 0; ifc.rD1 = 0; ifc.rD2 = 0; ifc.pc = 0; ifc.ext = 0;
      ifc.exm_we = 0; ifc.exm_rd = 0; ifc.exm_data = 0;
      ifc.mwb_we = 0; ifc.mwb_rd = 0; ifc.mwb_data = 0;
      ifc.flush = 0; ifc.out_ready = 1;
   endtask

   task automatic rand_bundle();
      ifc.alua_sel = 1'($urandom_range(0, 3) == 0);
      ifc.alub_sel = 1'($urandom_range(0, 3) == 0);
      ifc.rs1 = RW'($urandom_range(0, 3)); ifc.rs2 = RW'($urandom_range(0, 3));
      ifc.rD1 = $urandom; ifc.rD2 = $urandom; ifc.pc = $urandom; ifc.ext = $urandom;
      ifc.exm_we = 1'($urandom); ifc.exm_rd = RW'($urandom_range(0, 3)); ifc.exm_data = $urandom;
      ifc.mwb_we = 1'($urandom); ifc.mwb_rd = RW'($urandom_range(0, 3)); ifc.mwb_data = $urandom;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      ifc.in_valid = 1;
      rand_bundle();
      model_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if ({ifc.out_valid, ifc.A, ifc.B, ifc.fwd_a, ifc.fwd_b} !== {1'b0, 32'h0, 32'h0, 2'd0, 2'd0}) begin
         failures++;
         $display("FAIL reset_state: actual v=%0b A=%h B=%h fa=%0d fb=%0d required v=0 A=0 B=0 fa=0 fb=0",
                  ifc.out_valid, ifc.A, ifc.B, ifc.fwd_a, ifc.fwd_b);
      end
      rst_n = 1;
      ifc.alua_sel = 0; ifc.alub_sel = 0; ifc.rs1 = 7; ifc.rs2 = 8;
      ifc.rD1 = 32'h1111_0001; ifc.rD2 = 32'h2222_0002; ifc.exm_we = 0; ifc.mwb_we = 0;
      step();
      checks++;
      if ({ifc.out_valid, ifc.A, ifc.B} !== {1'b1, 32'h1111_0001, 32'h2222_0002}) begin
         failures++;
         $display("FAIL first_xfer: actual v=%0b A=%h B=%h required v=1 A=11110001 B=22220002",
                  ifc.out_valid, ifc.A, ifc.B);
      end
   endtask

   task automatic test_fwd_priority();
      logic [W-1:0] eb;
      logic [1:0]   ef;
      idle_inputs();
      ifc.in_valid = 1; ifc.rs2 = 5; ifc.rD2 = 32'hCCCC;
      ifc.exm_we = 1; ifc.exm_rd = 5; ifc.exm_data = 32'hAAAA;
      ifc.mwb_we = 1; ifc.mwb_rd = 5; ifc.mwb_data = 32'hBBBB;
`ifdef ALU_OPERAND_FWD_EN
      eb = 32'hAAAA; ef = 2'd1;
`else
      eb = 32'hCCCC; ef = 2'd0;
`endif
      step();
      checks++;
      if ({ifc.B, ifc.fwd_b} !== {eb, ef}) begin
         failures++;
         $display("FAIL fwd_priority: actual B=%h fb=%0d required B=%h fb=%0d", ifc.B, ifc.fwd_b, eb, ef);
      end
      // MEM/WB alone on rs1
      ifc.rs1 = 9; ifc.rD1 = 32'h0D01; ifc.exm_rd = 3; ifc.mwb_rd = 9;
`ifdef ALU_OPERAND_FWD_EN
      eb = 32'hBBBB; ef = 2'd2;
`else
      eb = 32'h0D01; ef = 2'd0;
`endif
      step();
      checks++;
      if ({ifc.A, ifc.fwd_a} !== {eb, ef}) begin
         failures++;
         $display("FAIL fwd_mwb: actual A=%h fa=%0d required A=%h fa=%0d", ifc.A, ifc.fwd_a, eb, ef);
      end
   endtask

   task automatic test_zero_index();
      idle_inputs();
      ifc.in_valid = 1; ifc.rs1 = 0; ifc.rD1 = 0;
      ifc.exm_we = 1; ifc.exm_rd = 0; ifc.exm_data = 32'h1234;
      ifc.mwb_we = 1; ifc.mwb_rd = 0; ifc.mwb_data = 32'h5678;
      step();
      checks++;
      if ({ifc.A, ifc.fwd_a} !== {32'h0, 2'd0}) begin
         failures++;
         $display("FAIL zero_index: actual A=%h fa=%0d required A=0 fa=0", ifc.A, ifc.fwd_a);
      end
   endtask

   task automatic test_imm_override();
      idle_inputs();
      ifc.in_valid = 1; ifc.alub_sel = 1; ifc.ext = 32'hFFFF_FFF0; ifc.rs2 = 6;
      ifc.exm_we = 1; ifc.exm_rd = 6; ifc.exm_data = 32'h7777;
      ifc.alua_sel = 1; ifc.pc = 32'h0000_4000; ifc.rs1 = 6;
      step();
      checks++;
      if ({ifc.A, ifc.fwd_a, ifc.B, ifc.fwd_b} !== {32'h0000_4000, 2'd0, 32'hFFFF_FFF0, 2'd0}) begin
         failures++;
         $display("FAIL imm_override: actual A=%h fa=%0d B=%h fb=%0d required A=00004000 fa=0 B=fffffff0 fb=0",
                  ifc.A, ifc.fwd_a, ifc.B, ifc.fwd_b);
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] ha, hb;
      idle_inputs();
      ifc.in_valid = 1; ifc.rs1 = 1; ifc.rs2 = 2; ifc.rD1 = 32'hA0A0; ifc.rD2 = 32'hB0B0;
      step();
      ha = 32'hA0A0; hb = 32'hB0B0;
      ifc.out_ready = 0; ifc.rD1 = 32'hA1A1; ifc.rD2 = 32'hB1B1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (ifc.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_in_ready[%0d]: actual %0b required 0", i, ifc.in_ready);
         end
         step();
         checks++;
         if ({ifc.out_valid, ifc.A, ifc.B} !== {1'b1, ha, hb}) begin
            failures++;
            $display("FAIL bp_hold[%0d]: actual v=%0b A=%h B=%h required v=1 A=%h B=%h",
                     i, ifc.out_valid, ifc.A, ifc.B, ha, hb);
         end
      end
      ifc.out_ready = 1;
      #1;
      checks++;
      if (ifc.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release_ready: actual %0b required 1", ifc.in_ready);
      end
      step();
      checks++;
      if ({ifc.out_valid, ifc.A, ifc.B} !== {1'b1, 32'hA1A1, 32'hB1B1}) begin
         failures++;
         $display("FAIL bp_release_load: actual v=%0b A=%h B=%h required v=1 A=0000a1a1 B=0000b1b1",
                  ifc.out_valid, ifc.A, ifc.B);
      end
      // consumed with nothing behind it: valid drops
      ifc.in_valid = 0;
      step();
      checks++;
      if (ifc.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL drain: actual v=%0b required 0", ifc.out_valid);
      end
   endtask

   task automatic test_flush();
      idle_inputs();
      ifc.in_valid = 1; ifc.rs1 = 3; ifc.rs2 = 4; ifc.rD1 = 32'hF00D; ifc.rD2 = 32'hBEEF;
      step();
      ifc.rD1 = 32'h1; ifc.rD2 = 32'h2; ifc.flush = 1; ifc.out_ready = 1;
      step();
      checks++;
      if ({ifc.out_valid, ifc.A, ifc.B} !== {1'b0, 32'hF00D, 32'hBEEF}) begin
         failures++;
         $display("FAIL flush: actual v=%0b A=%h B=%h required v=0 A=0000f00d B=0000beef",
                  ifc.out_valid, ifc.A, ifc.B);
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      ifc.in_valid = 1; ifc.rD1 = 32'h55; ifc.rD2 = 32'h66; ifc.rs1 = 1; ifc.rs2 = 1;
      step();
      ifc.out_ready = 0;
      rst_n = 0;
      model_reset();
      #1;
      checks++;
      if ({ifc.out_valid, ifc.A, ifc.B} !== {1'b0, 32'h0, 32'h0}) begin
         failures++;
         $display("FAIL reset_mid: actual v=%0b A=%h B=%h required v=0 A=0 B=0",
                  ifc.out_valid, ifc.A, ifc.B);
      end
      @(posedge clk); #1;
      rst_n = 1;
      ifc.in_valid = 0; ifc.out_ready = 1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rand_bundle();
         ifc.in_valid  = 1'($urandom_range(0, 3) != 0);
         ifc.out_ready = 1'($urandom_range(0, 2) != 0);
         ifc.flush     = 1'($urandom_range(0, 7) == 0);
         #1;
         checks++;
         if (ifc.in_ready !== (!exp_valid || ifc.out_ready)) begin
            failures++;
            $display("FAIL rand_in_ready[%0d]: actual %0b required %0b", i, ifc.in_ready,
                     (!exp_valid || ifc.out_ready));
         end
         step();
         checks++;
         if ({ifc.out_valid, ifc.A, ifc.B, ifc.fwd_a, ifc.fwd_b} !== {exp_valid, exp_a, exp_b, exp_fa, exp_fb}) begin
            failures++;
            $display("FAIL rand_out[%0d]: actual v=%0b A=%h B=%h fa=%0d fb=%0d required v=%0b A=%h B=%h fa=%0d fb=%0d",
                     i, ifc.out_valid, ifc.A, ifc.B, ifc.fwd_a, ifc.fwd_b,
                     exp_valid, exp_a, exp_b, exp_fa, exp_fb);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fwd_priority();
      test_zero_index();
      test_imm_override();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter WIDTH, default 32: operand and data width in bits.
REQ-002 Parameter RADDR_W, default 5: register-index width.
REQ-003 Parameter PC_RESET, default 0: reset value of the A and B output registers.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  the ID/EX operand bundle is valid.
REQ-007 in_ready  output  1  the stage accepts the bundle this cycle.
REQ-008 alua_sel  input  1  0 selects the rs1 path for A; 1 selects pc.
REQ-009 alub_sel  input  1  0 selects the rs2 path for B; 1 selects ext.
REQ-010 rs1, rs2  input  RADDR_W each  source register indices.
REQ-011 rD1, rD2, pc, ext  input  WIDTH each  register-file reads, pc and extended immediate.
REQ-012 exm_we, exm_rd, exm_data  input  1/RADDR_W/WIDTH  EX/MEM writeback candidate.
REQ-013 mwb_we, mwb_rd, mwb_data  input  1/RADDR_W/WIDTH  MEM/WB writeback candidate.
REQ-014 flush  input  1  discard the held and the incoming bundle.
REQ-015 out_valid  output  1  A and B are valid.
REQ-016 out_ready  input  1  the ALU consumes A and B this cycle.
REQ-017 A, B  output  WIDTH each  registered ALU operands.
REQ-018 fwd_a, fwd_b  output  2 each  registered forwarding source: 0 none, 1 EX/MEM, 2 MEM/WB.

Function
REQ-019 in_ready shall equal !out_valid || out_ready, combinationally.
REQ-020 A transfer shall occur when in_valid && in_ready; the output registers shall load on the next edge, giving one-cycle latency.
REQ-021 The rs1 path shall take exm_data when exm_we, exm_rd==rs1 and rs1!=0; otherwise mwb_data when mwb_we, mwb_rd==rs1 and rs1!=0; otherwise rD1.
REQ-022 The rs2 path shall use the same rule as REQ-021, with rs2 and rD2.
REQ-023 EX/MEM shall take priority over MEM/WB when both match.
REQ-024 When alua_sel=1, A shall be pc and fwd_a shall be 0; when alub_sel=1, B shall be ext and fwd_b shall be 0.
REQ-025 If out_ready is deasserted while out_valid=1, A, B, fwd_a and fwd_b shall hold unchanged.
REQ-026 When out_ready=1 and no transfer occurs, out_valid shall clear on the next edge.
REQ-027 flush shall clear out_valid on the next edge and suppress any transfer in the same cycle.
REQ-028 flush shall take priority over in_valid.
REQ-029 Data registers shall load only on a transfer; flush alone shall not modify A or B.
REQ-030 All operand arithmetic shall be pure selection with no width change; index 0 shall never forward.

Reset
REQ-031 While rst_n=0: out_valid=0; A=B=PC_RESET truncated to WIDTH; fwd_a=fwd_b=0.
REQ-032 A reset asserted mid-handshake shall discard the held bundle.
REQ-033 The first transfer shall be possible on the first edge after rst_n rises.

Configuration
REQ-034 Macro ALU_OPERAND_FWD_EN defined: forwarding shall operate per REQ-021 to REQ-023.
REQ-035 Macro ALU_OPERAND_FWD_EN absent: the rs1 path shall be rD1 and the rs2 path rD2, fwd_a=fwd_b=0 always, and the exm_*/mwb_* ports shall remain present but be ignored.

Structure
REQ-036 Package alu_operand_pkg shall hold the fwd encodings FWD_NONE=0, FWD_EXM=1 and FWD_MWB=2, and the alua/alub select constants.
REQ-037 Sub-module fwd_sel shall be one combinational forwarding selector, instantiated twice (rs1 and rs2 paths).
REQ-038 Handshake and output registers shall reside in alu_operand_stage.

Verification
REQ-039 Reset: rst_n=0 with in_valid=1 -> out_valid=0, A=B=0, fwd=0; rst_n released -> first transfer next edge.
REQ-040 Forward priority: rs2=5, exm_we=1, exm_rd=5, exm_data=0xAAAA, mwb_rd=5, mwb_data=0xBBBB -> B=0xAAAA, fwd_b=1.
REQ-041 Zero index: rs1=0, exm_we=1, exm_rd=0, exm_data=0x1234, rD1=0 -> A=0, fwd_a=0.
REQ-042 Immediate override: alub_sel=1, ext=0xFFFFFFF0, rs2 matches EX/MEM -> B=0xFFFFFFF0, fwd_b=0.
REQ-043 Backpressure: out_valid=1, out_ready=0 for 3 cycles, new in_valid=1 -> in_ready=0 and A/B stable; out_ready=1 -> new bundle loads next edge.
REQ-044 Flush: in_valid=1 and flush=1 in the same cycle with out_valid=1 -> out_valid=0 next edge and A/B unchanged; rerun with ALU_OPERAND_FWD_EN undefined -> REQ-040 gives B=rD2, fwd_b=0.
